mpsoc_ahb3_sram_ctrl: RTL and testbench
=======================================

// Module: mpsoc_ahb3_sram_ctrl
// PURPOSE
//  Per-node AHB3-Lite slave front-end driven by one riscv_mpsoc2d ahb3_ext_* master port.
//  Decodes transfers, checks size/alignment/range and builds byte enables.
//  Drives a single-port, 1-cycle-latency SRAM macro port.
//  Supports programmable wait states and the 2-cycle AHB ERROR response.
// PARAMETERS
//  PLEN        32    AHB address width
//  XLEN        32    data width (32 or 64)
//  MEM_BYTES   1024  memory size in bytes (power of 2)
//  WAIT_STATES 0     extra HREADYOUT-low cycles inserted before each memory access (0..15)
//  MEM_ABITS   derived: $clog2(MEM_BYTES/(XLEN/8)); word address width
// PORTS
//  clk        in   1          clock
//  rst        in   1          synchronous reset, active-high
//  HSEL       in   1          slave select
//  HADDR      in   PLEN       address
//  HWDATA     in   XLEN       write data (data phase)
//  HWRITE     in   1          1=write
//  HSIZE      in   3          transfer size
//  HBURST     in   3          burst type (ignored; each beat decoded on its own)
//  HPROT      in   4          protection (ignored)
//  HTRANS     in   2          IDLE/BUSY/NONSEQ/SEQ
//  HMASTLOCK  in   1          lock (ignored)
//  HREADY     in   1          bus ready (address-phase qualifier)
//  HRDATA     out  XLEN       read data
//  HREADYOUT  out  1          slave ready
//  HRESP      out  1          0=OKAY, 1=ERROR
//  mem_req    out  1          SRAM access strobe
//  mem_we     out  1          SRAM write enable
//  mem_be     out  XLEN/8     SRAM byte enables
//  mem_addr   out  MEM_ABITS  SRAM word address
//  mem_wdata  out  XLEN       SRAM write data
//  mem_rdata  in   XLEN       SRAM read data, valid the cycle after mem_req & !mem_we
// BEHAVIOUR
//  Reset: HREADYOUT=1, HRESP=0, HRDATA=0, mem_req=0, mem_we=0, mem_be=0; FSM=IDLE.
//  Accept when HSEL & HREADY & HTRANS[1] (NONSEQ/SEQ). On accept, latch addr, write, size, be.
//  IDLE/BUSY or unselected transfers: OKAY, zero wait, no memory access.
//  Error check at accept:
//    - HADDR >= MEM_BYTES, or HSIZE > log2(XLEN/8), or HADDR not aligned to 2^HSIZE.
//    - Response: ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1).
//    - No mem_req is issued.
//  Byte enables: ((1<<2^size)-1) << HADDR[$clog2(XLEN/8)-1:0].
//  FSM states: IDLE, WAIT, RD_ISSUE, RD_DATA, WR, ERR1, ERR2.
//    - Accept moves to WAIT if WAIT_STATES>0; otherwise to RD_ISSUE / WR / ERR1.
//    - WAIT: HREADYOUT=0, down-counter from WAIT_STATES-1. At 0, go to RD_ISSUE or WR.
//    - RD_ISSUE: mem_req=1, mem_we=0, HREADYOUT=0; next state is RD_DATA.
//    - RD_DATA: HRDATA=mem_rdata (registered hold until next read), HREADYOUT=1, HRESP=0.
//    - WR: mem_req=1, mem_we=1, mem_wdata=HWDATA, HREADYOUT=1; write commits this cycle.
//    - From RD_DATA, WR or ERR2 (HREADYOUT=1), a new accept pipelines directly; otherwise go to IDLE.
//  Latency:
//    - Read: data phase is WAIT_STATES+2 cycles.
//    - Write: data phase is WAIT_STATES+1 cycles.
//    - Error: data phase is 2 cycles, independent of WAIT_STATES.
//  Write followed by read of the same address, back to back:
//    - The write commits in WR; the read issues in the next cycle.
//    - The read returns the new data. No forwarding path is needed.
//  Single port: at most one mem_req per cycle by construction.
//  Reset mid-transfer: on the reset edge go to IDLE; mem_req/mem_we drop the same cycle; no late write.
// STRUCTURE
//  Shared package mpsoc_ahb3_pkg holds:
//    - HTRANS_IDLE/BUSY/NONSEQ/SEQ
//    - HSIZE_BYTE/HWORD/WORD/DWORD
//    - HRESP_OKAY/ERROR
//    - function ahb3_byte_enable(size, addr_lsb, XLEN)
//  FSM enum is local to the module. No sub-module; the SRAM macro is instantiated by the parent.
// TESTING
//  1. Write word: 0xDEADBEEF to 0x10 (W=0).
//     -> WR cycle: mem_be=4'hF, mem_addr=4. Read 0x10 -> HRDATA=0xDEADBEEF after 2 cycles.
//  2. Byte write: HSIZE=0 to 0x13, HWDATA[31:24]=0xAA.
//     -> mem_be=4'b1000. Word read of 0x10 -> 0xAAADBEEF.
//  3. Out of range: read 0x400 (MEM_BYTES=1024).
//     -> ERR1 then ERR2 (HRESP=1, HREADYOUT 0 then 1). mem_req never asserted.
//     Misaligned: halfword at 0x1 -> same ERROR.
//  4. WAIT_STATES=2.
//     -> Read: HREADYOUT low 3 cycles then high. Write: low 2 cycles, mem_we on the 3rd.
//  5. Pipelined sequence: write 0x20 = 0x12345678, then read 0x20, then IDLE.
//     -> Read returns 0x12345678. HREADYOUT pattern 1,0,1. No cycle has two accesses.
//  6. Reset asserted during RD_ISSUE or during WAIT before a write.
//     -> Next cycle: HREADYOUT=1, HRESP=0, mem_req=0. Memory content unchanged.

Source files
------------

// File: rtl/mpsoc_ahb3_pkg.sv
// Shared AHB3-Lite encodings and byte-enable helper for the per-node slave front-ends.
// Pure definitions; no state, no latency.
package mpsoc_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HWORD = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Lane mask for a transfer of 2^size bytes starting at addr_lsb; lanes beyond XLEN/8 are ignored by callers.
  function automatic logic [7:0] ahb3_byte_enable(input logic [2:0] size,
                                                  input logic [2:0] addr_lsb,
                                                  input int         xlen);
    logic [7:0] mask;
    logic [2:0] lsb;
    case (size)
      HSIZE_BYTE:  mask = 8'h01;
      HSIZE_HWORD: mask = 8'h03;
      HSIZE_WORD:  mask = 8'h0F;
      HSIZE_DWORD: mask = 8'hFF;
      default:     mask = 8'hFF;
    endcase
    lsb = (xlen == 64) ? addr_lsb : {1'b0, addr_lsb[1:0]};
    return mask << lsb;
  endfunction

endpackage

// File: rtl/mpsoc_ahb3_sram_ctrl.sv
// AHB3-Lite slave to single-port 1-cycle SRAM bridge with range/size/alignment checking.
// Data phase: read WAIT_STATES+2, write WAIT_STATES+1, error 2 cycles; stalls the bus via HREADYOUT.
module mpsoc_ahb3_sram_ctrl
  import mpsoc_ahb3_pkg::*;
#(
  parameter  int PLEN        = 32,
  parameter  int XLEN        = 32,
  parameter  int MEM_BYTES   = 1024,
  parameter  int WAIT_STATES = 0,
  localparam int MEM_ABITS   = $clog2(MEM_BYTES / (XLEN / 8))
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   HSEL,
  input  logic [PLEN-1:0]        HADDR,
  input  logic [XLEN-1:0]        HWDATA,
  input  logic                   HWRITE,
  input  logic [2:0]             HSIZE,
  input  logic [2:0]             HBURST,
  input  logic [3:0]             HPROT,
  input  logic [1:0]             HTRANS,
  input  logic                   HMASTLOCK,
  input  logic                   HREADY,
  output logic [XLEN-1:0]        HRDATA,
  output logic                   HREADYOUT,
  output logic                   HRESP,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [XLEN/8-1:0]      mem_be,
  output logic [MEM_ABITS-1:0]   mem_addr,
  output logic [XLEN-1:0]        mem_wdata,
  input  logic [XLEN-1:0]        mem_rdata
);

  localparam int BE_W = XLEN / 8;
  localparam int OFF  = $clog2(BE_W);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_RD_ISSUE, S_RD_DATA, S_WR, S_ERR1, S_ERR2
  } state_t;

  state_t                r_state;
  state_t                w_nxt;
  logic                  r_hreadyout;
  logic                  r_hresp;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic                  r_write;
  logic [3:0]            r_cnt;
  logic [MEM_ABITS-1:0]  r_waddr;
  logic [BE_W-1:0]       r_be;
  logic [XLEN-1:0]       r_rdata;

  logic                  w_accept;
  logic                  w_range_err;
  logic                  w_size_err;
  logic                  w_misalign;
  logic                  w_err;
  logic [7:0]            w_be8;
  logic [BE_W-1:0]       w_be;
  logic                  w_unused;

  // Only a ready data phase (or none) can take a new address phase.
  assign w_accept    = HSEL & HREADY & HTRANS[1] & r_hreadyout;
  assign w_range_err = (HADDR >= PLEN'(MEM_BYTES));
  assign w_size_err  = (HSIZE > 3'(OFF));
  assign w_misalign  = |(HADDR[7:0] & ((8'd1 << HSIZE) - 8'd1));
  assign w_err       = w_range_err | w_size_err | w_misalign;
  assign w_be8       = ahb3_byte_enable(HSIZE, HADDR[2:0], XLEN);
  assign w_be        = w_be8[BE_W-1:0];
  assign w_unused    = ^{HBURST, HPROT, HMASTLOCK, w_be8};

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_WAIT:     if (r_cnt == 4'd0) w_nxt = r_write ? S_WR : S_RD_ISSUE;
      S_RD_ISSUE: w_nxt = S_RD_DATA;
      S_ERR1:     w_nxt = S_ERR2;
      default: begin
        if (!w_accept)             w_nxt = S_IDLE;
        else if (w_err)            w_nxt = S_ERR1;
        else if (WAIT_STATES > 0)  w_nxt = S_WAIT;
        else                       w_nxt = HWRITE ? S_WR : S_RD_ISSUE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_write     <= 1'b0;
      r_cnt       <= 4'd0;
      r_waddr     <= '0;
      r_be        <= '0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_nxt;
      r_hreadyout <= !(w_nxt inside {S_WAIT, S_RD_ISSUE, S_ERR1});
      r_hresp     <= (w_nxt == S_ERR1 || w_nxt == S_ERR2) ? HRESP_ERROR : HRESP_OKAY;
      r_mem_req   <= (w_nxt == S_RD_ISSUE) || (w_nxt == S_WR);
      r_mem_we    <= (w_nxt == S_WR);
      if (w_accept) begin
        r_write <= HWRITE;
        r_waddr <= HADDR[OFF +: MEM_ABITS];
        r_be    <= w_be;
        r_cnt   <= 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == S_RD_DATA) r_rdata <= mem_rdata;
    end
  end

  // Read data flows straight from the macro in RD_DATA and is held afterwards.
  assign HRDATA    = (r_state == S_RD_DATA) ? mem_rdata : r_rdata;
  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_req ? r_be : '0;
  assign mem_addr  = r_waddr;
  assign mem_wdata = HWDATA;

endmodule

// File: tb/tb_mpsoc_ahb3_sram_ctrl.sv
// Scoreboard bench: two controllers (0 and 2 wait states) behind one AHB master, each with an SRAM model.
module tb_mpsoc_ahb3_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsel = 1'b0;
  logic        hwrite = 1'b0;
  logic [31:0] haddr = '0;
  logic [31:0] hwdata = '0;
  logic [2:0]  hsize = '0;
  logic [1:0]  htrans = '0;
  int          sel = 0;

  always #5 clk = ~clk;

  logic [31:0] hrdata0, hrdata2, wd0, wd2, rd0, rd2;
  logic        ro0, ro2, rsp0, rsp2, req0, req2, we0, we2;
  logic [3:0]  be0, be2;
  logic [7:0]  ad0, ad2;

  mpsoc_ahb3_sram_ctrl #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .HSEL(hsel && sel == 0), .HADDR(haddr), .HWDATA(hwdata),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011), .HTRANS(htrans),
    .HMASTLOCK(1'b0), .HREADY(ro0), .HRDATA(hrdata0), .HREADYOUT(ro0), .HRESP(rsp0),
    .mem_req(req0), .mem_we(we0), .mem_be(be0), .mem_addr(ad0), .mem_wdata(wd0),
    .mem_rdata(rd0));

  mpsoc_ahb3_sram_ctrl #(.WAIT_STATES(2)) u_dut2 (
    .clk(clk), .rst(rst), .HSEL(hsel && sel == 1), .HADDR(haddr), .HWDATA(hwdata),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011), .HTRANS(htrans),
    .HMASTLOCK(1'b0), .HREADY(ro2), .HRDATA(hrdata2), .HREADYOUT(ro2), .HRESP(rsp2),
    .mem_req(req2), .mem_we(we2), .mem_be(be2), .mem_addr(ad2), .mem_wdata(wd2),
    .mem_rdata(rd2));

  logic [31:0] mem0 [256];
  logic [31:0] mem2 [256];

  always @(posedge clk) begin
    if (req0) begin
      if (we0) begin
        for (int b = 0; b < 4; b++) if (be0[b]) mem0[ad0][8*b +: 8] <= wd0[8*b +: 8];
      end else begin
        rd0 <= mem0[ad0];
      end
    end
    if (req2) begin
      if (we2) begin
        for (int b = 0; b < 4; b++) if (be2[b]) mem2[ad2][8*b +: 8] <= wd2[8*b +: 8];
      end else begin
        rd2 <= mem2[ad2];
      end
    end
  end

  logic        rdy_m, rsp_m, req_m, we_m;
  logic [31:0] hrdata_m;
  logic [3:0]  be_m;
  logic [7:0]  ad_m;
  assign rdy_m    = (sel == 1) ? ro2 : ro0;
  assign rsp_m    = (sel == 1) ? rsp2 : rsp0;
  assign req_m    = (sel == 1) ? req2 : req0;
  assign we_m     = (sel == 1) ? we2 : we0;
  assign hrdata_m = (sel == 1) ? hrdata2 : hrdata0;
  assign be_m     = (sel == 1) ? be2 : be0;
  assign ad_m     = (sel == 1) ? ad2 : ad0;

  typedef struct {
    bit          wr;
    bit          err;
    logic [31:0] data;
    logic [3:0]  be;
    logic [7:0]  waddr;
    int          lows;
  } exp_t;

  exp_t        sb_q [$];
  exp_t        mon_e;
  logic [31:0] ref_m [2][256];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          dph = 1'b0;
  int          lows = 0;
  int          reqs = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Data-phase monitor: counts stall cycles and SRAM strobes, checks the beat when HREADYOUT rises.
  always @(negedge clk) begin
    if (rst) begin
      dph = 1'b0;
      sb_q.delete();
    end else begin
      if (dph) begin
        if (req_m) reqs++;
        if (!rdy_m) lows++;
        else begin
          if (sb_q.size() == 0) check_eq("sb_empty", sb_q.size(), 1);
          else begin
            mon_e = sb_q.pop_front();
            check_eq("stall_cycles", lows, mon_e.lows);
            check_eq("mem_accesses", reqs, mon_e.err ? 0 : 1);
            check_eq("hresp", rsp_m, mon_e.err);
            if (!mon_e.err && mon_e.wr) begin
              check_eq("wr_mem_we", we_m, 1);
              check_eq("wr_mem_be", be_m, mon_e.be);
              check_eq("wr_mem_addr", ad_m, mon_e.waddr);
            end else if (!mon_e.err) begin
              check_eq("rd_hrdata", hrdata_m, mon_e.data);
            end
          end
          dph = 1'b0;
        end
      end
      if (hsel && htrans[1] && rdy_m) begin
        dph  = 1'b1;
        lows = 0;
        reqs = 0;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!rdy_m && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_eq("ready_timeout", rdy_m, 1);
  endtask

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata);
    exp_t       e;
    int         ws;
    int         nbytes;
    logic [7:0] m;
    logic [7:0] be8;
    hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = addr; hsize = size;
    wait_ready();
    ws     = (sel == 1) ? 2 : 0;
    nbytes = 1 << size;
    m      = 8'((1 << nbytes) - 1);
    be8    = m << addr[1:0];
    e.wr    = wr;
    e.err   = (addr >= 32'd1024) || (size > 3'd2) || ((addr & ((32'd1 << size) - 32'd1)) != 0);
    e.be    = be8[3:0];
    e.waddr = addr[9:2];
    e.lows  = e.err ? 1 : (wr ? ws : ws + 1);
    e.data  = e.err ? 32'h0 : ref_m[sel][addr[9:2]];
    if (wr && !e.err)
      for (int b = 0; b < 4; b++) if (e.be[b]) ref_m[sel][addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
    sb_q.push_back(e);
    @(posedge clk); #1;
    if (wr) hwdata = wdata;
  endtask

  task automatic drain();
    int n = 0;
    hsel = 1'b0; htrans = 2'b00;
    while ((dph || sb_q.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) check_eq("drain_timeout", sb_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Accepts one transfer, then hits reset in its first data-phase cycle.
  task automatic reset_mid(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = addr; hsize = 3'd2;
    wait_ready();
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wdata;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_hreadyout", rdy_m, 1);
    check_eq("rst_mid_hresp", rsp_m, 0);
    check_eq("rst_mid_mem_req", req_m, 0);
    check_eq("rst_mid_hrdata", hrdata_m, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_hreadyout", ro0, 1);
    check_eq("rst_hresp", rsp0, 0);
    check_eq("rst_hrdata", hrdata0, 0);
    check_eq("rst_mem_req", req0, 0);
    check_eq("rst_mem_we", we0, 0);
    check_eq("rst_mem_be", be0, 0);
    check_eq("rst_hreadyout_ws2", ro2, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    sel = 0;
    issue(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    drain();
    issue(1'b0, 32'h10, 3'd2, 32'h0);
    drain();
    issue(1'b1, 32'h13, 3'd0, 32'hAA000000);
    issue(1'b0, 32'h10, 3'd2, 32'h0);
    issue(1'b0, 32'h400, 3'd2, 32'h0);
    issue(1'b0, 32'h1, 3'd1, 32'h0);
    issue(1'b0, 32'h8, 3'd3, 32'h0);
    issue(1'b1, 32'h7FC, 3'd2, 32'h55555555);
    issue(1'b0, 32'h10, 3'd2, 32'h0);
    issue(1'b1, 32'h3FC, 3'd2, 32'hCAFEF00D);
    issue(1'b1, 32'h3FE, 3'd1, 32'h1234FFFF);
    issue(1'b0, 32'h3FC, 3'd2, 32'h0);
    drain();
    issue(1'b1, 32'h20, 3'd2, 32'h12345678);
    issue(1'b0, 32'h20, 3'd2, 32'h0);
    drain();
    reset_mid(1'b0, 32'h10, 32'h0);
    issue(1'b0, 32'h10, 3'd2, 32'h0);
    drain();

    sel = 1;
    issue(1'b1, 32'h40, 3'd2, 32'h0BADF00D);
    issue(1'b0, 32'h40, 3'd2, 32'h0);
    issue(1'b0, 32'h404, 3'd2, 32'h0);
    issue(1'b1, 32'h45, 3'd0, 32'h00007700);
    issue(1'b0, 32'h44, 3'd2, 32'h0);
    issue(1'b1, 32'h42, 3'd2, 32'hFFFFFFFF);
    drain();
    reset_mid(1'b1, 32'h40, 32'hFFFFFFFF);
    issue(1'b0, 32'h40, 3'd2, 32'h0);
    drain();

    check_eq("sb_leftover", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
